// File: rtl/dmac_burst_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_burst_scheduler_if
//  Brief    : Request and burst-command bus for the DMA burst scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmac_burst_scheduler_if #(
  parameter int W_EXT_A = 32,
  parameter int W_SIZE  = 32,
  parameter int W_BLEN  = 9
);
  logic               req_valid;
  logic               req_ready;
  logic               req_read;
  logic               req_write;
  logic [W_EXT_A-1:0] req_addr;
  logic [W_SIZE-1:0]  req_word_size;
  logic [W_EXT_A-1:0] ext_addr;
  logic               ext_read_enable;
  logic               ext_write_enable;
  logic [W_BLEN-1:0]  ext_word_size;
  logic               ext_ready;
  logic               busy;
  logic               done;

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_word_size, ext_ready,
    output req_ready, ext_addr, ext_read_enable, ext_write_enable,
           ext_word_size, busy, done
  );

  modport master (
    output req_valid, req_read, req_write, req_addr, req_word_size, ext_ready,
    input  req_ready, ext_addr, ext_read_enable, ext_write_enable,
           ext_word_size, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/dmac_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dmac_burst_scheduler
//  Brief    : Splits a word transfer into bursts limited by length and address
//             boundary. Optional DMAC_BURST_SCHEDULER_STATS_EN adds burst_count.
//  Revision : 1.0 - initial release
// ============================================================================
module dmac_burst_scheduler #(
  parameter int W_D           = 32,
  parameter int W_EXT_A       = 32,
  parameter int W_BOUNDARY_A  = 12,
  parameter int W_BLEN        = 9,
  parameter int MAX_BURST_LEN = 256,
  parameter int W_SIZE        = 32
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  dmac_burst_scheduler_if.slave bus
`ifdef DMAC_BURST_SCHEDULER_STATS_EN
  ,
  output logic [15:0]          burst_count
`endif
);
  localparam int c_byte_sh  = $clog2(W_D / 8);
  localparam int c_w_room   = W_BOUNDARY_A + 1;
  localparam int c_w_calc_a = (W_SIZE > c_w_room) ? W_SIZE : c_w_room;
  localparam int c_w_calc   = (c_w_calc_a > W_BLEN) ? c_w_calc_a : W_BLEN;
  localparam logic [W_EXT_A-1:0] c_align_mask = W_EXT_A'((W_D / 8) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [W_EXT_A-1:0]  r_addr, w_addr_nxt;
  logic [W_SIZE-1:0]   r_remaining, w_remaining_nxt;
  logic                r_is_read, w_is_read_nxt;
  logic                r_req_ready, w_req_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_rd_en, w_rd_en_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [W_EXT_A-1:0]  r_ext_addr, w_ext_addr_nxt;
  logic [W_BLEN-1:0]   r_ext_len, w_ext_len_nxt;

  logic [c_w_room-1:0] w_room_bytes;
  logic [c_w_calc-1:0] w_room, w_rem, w_max, w_len;
  logic [W_SIZE-1:0]   w_rem_after;
  logic                w_handshake, w_accept;

  assign w_handshake = (r_state == S_IDLE) && r_req_ready && bus.req_valid;
  assign w_accept    = (r_state == S_ISSUE) && bus.ext_ready;

  // Burst length is the smallest of what is left, the burst cap and the
  // words remaining before the next boundary; all at a common wide width.
  assign w_room_bytes = {1'b1, {W_BOUNDARY_A{1'b0}}} - {1'b0, r_addr[W_BOUNDARY_A-1:0]};
  assign w_room       = c_w_calc'(w_room_bytes >> c_byte_sh);
  assign w_rem        = c_w_calc'(r_remaining);
  assign w_max        = c_w_calc'(MAX_BURST_LEN);
  assign w_rem_after  = r_remaining - W_SIZE'(r_ext_len);

  always_comb begin
    w_len = w_rem;
    if (w_max < w_len)  w_len = w_max;
    if (w_room < w_len) w_len = w_room;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_is_read_nxt   = r_is_read;
    w_req_ready_nxt = r_req_ready;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_rd_en_nxt     = r_rd_en;
    w_wr_en_nxt     = r_wr_en;
    w_ext_addr_nxt  = r_ext_addr;
    w_ext_len_nxt   = r_ext_len;
    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_handshake) begin
          w_req_ready_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_addr_nxt      = bus.req_addr & ~c_align_mask;
          w_remaining_nxt = bus.req_word_size;
          w_is_read_nxt   = bus.req_read;
          if ((!bus.req_read && !bus.req_write) || (bus.req_word_size == '0)) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_ext_addr_nxt = r_addr;
        w_ext_len_nxt  = W_BLEN'(w_len);
        w_rd_en_nxt    = r_is_read;
        w_wr_en_nxt    = !r_is_read;
        w_state_nxt    = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.ext_ready) begin
          w_rd_en_nxt     = 1'b0;
          w_wr_en_nxt     = 1'b0;
          w_addr_nxt      = r_addr + (W_EXT_A'(r_ext_len) << c_byte_sh);
          w_remaining_nxt = w_rem_after;
          if (w_rem_after == '0) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
          end
        end
      end
      default: begin
        w_busy_nxt      = 1'b0;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_is_read   <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_len   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_is_read   <= w_is_read_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_ext_addr  <= w_ext_addr_nxt;
      r_ext_len   <= w_ext_len_nxt;
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.ext_read_enable  = r_rd_en;
  assign bus.ext_write_enable = r_wr_en;
  assign bus.ext_addr         = r_ext_addr;
  assign bus.ext_word_size    = r_ext_len;

`ifdef DMAC_BURST_SCHEDULER_STATS_EN
  logic [15:0] r_burst_count;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_burst_count <= '0;
    end else if (w_handshake) begin
      r_burst_count <= '0;
    end else if (w_accept && (r_burst_count != 16'hFFFF)) begin
      r_burst_count <= r_burst_count + 16'd1;
    end
  end

  assign burst_count = r_burst_count;
`endif

endmodule
`default_nettype wire
